mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// Load/store front end between the MIPS datapath and DataRAM (word-addressed, word-wide,
// write-enable MemWR). Accepts byte/half/word loads and stores on byte addresses, checks
// alignment, performs sub-word stores as read-modify-write, and sign/zero-extends loads.
// Multi-cycle with a Busy stall output to the pipeline.
// PARAMETERS
// n  5  DataRAM word-address width; byte address is n+2 bits; data width fixed at 32
// PORTS
// Clk         in   1     clock, all state updates on rising edge
// Rst         in   1     synchronous, active-high reset
// Req         in   1     start access; sampled only in IDLE
// Wr          in   1     1 = store, 0 = load
// Size        in   2     00 byte, 01 half, 10 word, 11 illegal
// Unsigned    in   1     loads: 1 zero-extend, 0 sign-extend
// ByteAddr    in   n+2   byte address
// WData       in   32    store data, right-justified (byte in [7:0], half in [15:0])
// Busy        out  1     high whenever state != IDLE
// Done        out  1     one-cycle pulse: access complete
// AddrErr     out  1     valid with Done: misaligned/illegal, access not performed
// RData       out  32    extended load data, held until next load Done
// Ram_Addr    out  n     to DataRAM Addr
// Ram_DataIn  out  32    to DataRAM DataIn
// Ram_MemWR   out  1     to DataRAM MemWR
// Ram_DataOut in   32    from DataRAM DataOut (combinational read of Ram_Addr)
// BEHAVIOUR
// - Reset: state IDLE; Busy, Done, AddrErr, Ram_MemWR = 0; RData, Ram_Addr, Ram_DataIn = 0.
// - Big-endian lanes: byte offset 0 -> [31:24], 3 -> [7:0]; half offset 0 -> [31:16], 2 -> [15:0].
// - IDLE + Req: latch Wr, Size, Unsigned, ByteAddr, WData; Ram_Addr <= ByteAddr[n+1:2].
//   Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or Size=11 -> ERR; else
//   load -> READ; word store -> WRITE; byte/half store -> READ.
// - READ (1 cycle): capture Ram_DataOut into merge register. Load -> DONE with RData <=
//   selected lane, extended per Unsigned. Sub-word store -> WRITE with merge register lane
//   replaced by WData[7:0]/[15:0], other lanes preserved.
// - WRITE (1 cycle): Ram_DataIn = merged/full word; Ram_MemWR = 1 & ~Rst; RAM writes at
//   end of this cycle. -> DONE.
// - DONE: Done=1, AddrErr=0, -> IDLE. ERR: Done=1, AddrErr=1, no RAM write, RData unchanged,
//   -> IDLE.
// - Latency (Req sampled edge = cycle 0): load Done in cycle 2; word store Done cycle 2;
//   sub-word store Done cycle 3; error Done cycle 1. Back-to-back: next Req accepted in
//   the cycle after Done (IDLE).
// - Req while Busy (incl. DONE/ERR) ignored, not queued; input changes while Busy ignored.
// - Ram_MemWR high only in WRITE; never two consecutive cycles.
// - Rst mid-operation: Ram_MemWR forced 0 the same cycle (no partial write), next state
//   IDLE, all outputs to reset values.
// - Address wrap: none; top word 2^n-1 fully usable.
// TESTING
// 1 Rst, store word 0xDEADBEEF @0x08 -> Ram_MemWR=1 in cycle 1 only, Ram_Addr=2,
//   Ram_DataIn=0xDEADBEEF; Done cycle 2, AddrErr=0.
// 2 Load byte @0x09 signed -> RData=0xFFFFFFAD cycle 2; Unsigned=1 -> 0x000000AD;
//   load half @0x0A signed -> 0xFFFFBEEF.
// 3 Store half 0x1234 @0x0A -> READ, WRITE (Ram_DataIn=0xDEAD1234), Done cycle 3;
//   load word @0x08 -> 0xDEAD1234.
// 4 Load word @0x06, then Size=11 @0x00 -> Done+AddrErr cycle 1, Ram_MemWR never 1,
//   RData unchanged.
// 5 Req pulsed while Busy -> ignored; Rst asserted in WRITE of byte store @0x08 ->
//   Ram_MemWR=0, word 2 unchanged, Busy=0 next cycle.
// 6 Store byte 0x5A @ byte addr 4*2^n-1 -> top word [7:0]=0x5A, upper lanes preserved;
//   back-to-back Req on cycle after Done accepted.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bus of the load/store unit.
// Requests are sampled only while Busy is low; responses are qualified by Done.
interface mem_access_unit_if #(parameter int n = 5);
   logic          Req;
   logic          Wr;
   logic [1:0]    Size;
   logic          Unsigned;
   logic [n+1:0]  ByteAddr;
   logic [31:0]   WData;
   logic          Busy;
   logic          Done;
   logic          AddrErr;
   logic [31:0]   RData;

   modport master (
      output Req, Wr, Size, Unsigned, ByteAddr, WData,
      input  Busy, Done, AddrErr, RData
   );

   modport slave (
      input  Req, Wr, Size, Unsigned, ByteAddr, WData,
      output Busy, Done, AddrErr, RData
   );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end to a word-wide DataRAM; sub-word stores are read-modify-write.
// Done after 1 (error), 2 (load, word store) or 3 (sub-word store) cycles; Req while Busy is dropped.
module mem_access_unit #(
   parameter int n = 5
) (
   input  logic            Clk,
   input  logic            Rst,
   mem_access_unit_if.slave cpu,
   output logic [n-1:0]    Ram_Addr,
   output logic [31:0]     Ram_DataIn,
   output logic            Ram_MemWR,
   input  logic [31:0]     Ram_DataOut
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t        state;
   state_t        nextState;

   logic          wrQ;
   logic          unsignedQ;
   logic [1:0]    sizeQ;
   logic [1:0]    offsetQ;
   logic [31:0]   wDataQ;
   logic [31:0]   mergeQ;
   logic [31:0]   rDataQ;
   logic [n-1:0]  ramAddrQ;

   logic          reqErr;
   logic [4:0]    laneShift;
   logic [31:0]   laneMask;
   logic [31:0]   loadLane;
   logic [31:0]   loadExt;
   logic [31:0]   merged;

   // Alignment/legality check on the live request, only meaningful in IDLE.
   always_comb begin
      reqErr = 1'b0;
      case (cpu.Size)
         2'b01:   reqErr = cpu.ByteAddr[0];
         2'b10:   reqErr = |cpu.ByteAddr[1:0];
         2'b11:   reqErr = 1'b1;
         default: reqErr = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (cpu.Req) begin
               if (reqErr) begin
                  nextState = ERR;
               end else if (cpu.Wr && cpu.Size == 2'b10) begin
                  nextState = WRITE;
               end else begin
                  nextState = READ;
               end
            end
         end
         READ:    nextState = wrQ ? WRITE : DONE;
         WRITE:   nextState = DONE;
         DONE:    nextState = IDLE;
         ERR:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Reset gates the write strobe combinationally so an aborted store never lands.
   always_comb begin
      cpu.Busy    = (state != IDLE);
      cpu.Done    = (state == DONE) || (state == ERR);
      cpu.AddrErr = (state == ERR);
      Ram_MemWR   = (state == WRITE) && !Rst;
   end

   // Big-endian lanes: byte offset 0 is bits [31:24], half offset 0 is bits [31:16].
   always_comb begin
      laneShift = 5'd0;
      laneMask  = 32'hFFFF_FFFF;
      case (sizeQ)
         2'b00: begin
            laneShift = {~offsetQ, 3'b000};
            laneMask  = 32'h0000_00FF;
         end
         2'b01: begin
            laneShift = {~offsetQ[1], 4'b0000};
            laneMask  = 32'h0000_FFFF;
         end
         default: ;
      endcase

      loadLane = (Ram_DataOut >> laneShift) & laneMask;
      merged   = (Ram_DataOut & ~(laneMask << laneShift))
               | ((wDataQ & laneMask) << laneShift);

      case (sizeQ)
         2'b00:   loadExt = unsignedQ ? loadLane : {{24{loadLane[7]}}, loadLane[7:0]};
         2'b01:   loadExt = unsignedQ ? loadLane : {{16{loadLane[15]}}, loadLane[15:0]};
         default: loadExt = loadLane;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wrQ       <= 1'b0;
         unsignedQ <= 1'b0;
         sizeQ     <= 2'b00;
         offsetQ   <= 2'b00;
         wDataQ    <= 32'h0;
         mergeQ    <= 32'h0;
         rDataQ    <= 32'h0;
         ramAddrQ  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu.Req) begin
                  wrQ       <= cpu.Wr;
                  unsignedQ <= cpu.Unsigned;
                  sizeQ     <= cpu.Size;
                  offsetQ   <= cpu.ByteAddr[1:0];
                  wDataQ    <= cpu.WData;
                  ramAddrQ  <= cpu.ByteAddr[n+1:2];
                  if (cpu.Wr && cpu.Size == 2'b10 && !reqErr) begin
                     mergeQ <= cpu.WData;
                  end
               end
            end
            READ: begin
               if (wrQ) begin
                  mergeQ <= merged;
               end else begin
                  rDataQ <= loadExt;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu.RData  = rDataQ;
   assign Ram_Addr   = ramAddrQ;
   assign Ram_DataIn = mergeQ;

   a_noBackToBackWrite: assert property (@(posedge Clk) Ram_MemWR |=> !Ram_MemWR);

endmodule
